// File: rtl/user_imem_loader.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | user_imem_loader: packs UART bytes into 32-bit words for user imem.    |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module user_imem_loader #(
    parameter int IMEM_AW = 10
) (
    input  logic               hb_clk,
    input  logic               rst_n,
    input  logic               download_mode,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_waddr,
    output logic [31:0]        imem_wdata,
    input  logic [7:0]         sys_share_raddr,
    input  logic [7:0]         sys_share_waddr,
    input  logic [31:0]        sys_share_wdata,
    input  logic               sel_ren,
    input  logic               sel_wen,
    output logic [31:0]        rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [IMEM_AW:0] CAPACITY = {1'b1, {IMEM_AW{1'b0}}};

    state_t             state_q, state_d;
    logic [1:0]         byte_idx_q, byte_idx_d;
    logic [31:0]        word_q, word_d;
    logic [IMEM_AW:0]   len_q, len_d;
    logic [IMEM_AW:0]   count_q, count_d;
    logic [31:0]        csum_q, csum_d;
    logic               done_q, done_d;
    logic               aborted_q, aborted_d;
    logic               len_err_q, len_err_d;
    logic               imem_we_q, imem_we_d;
    logic [IMEM_AW-1:0] imem_waddr_q, imem_waddr_d;
    logic [31:0]        imem_wdata_q, imem_wdata_d;
    logic [31:0]        rdata_q, rdata_d;

    logic busy;
    logic ctrl_wr;
    logic start_req;
    logic abort_req;
    logic unused_wdata;

    assign unused_wdata = ^sys_share_wdata[31:IMEM_AW+1];

    assign busy      = (state_q == S_RECV) || (state_q == S_WRITE);
    assign ctrl_wr   = sel_wen && (sys_share_waddr == 8'd0);
    assign abort_req = (ctrl_wr && sys_share_wdata[1]) || (busy && !download_mode);
    assign start_req = ctrl_wr && sys_share_wdata[0] && download_mode && !abort_req;

    assign rx_ready   = (state_q == S_RECV);
    assign imem_we    = imem_we_q;
    assign imem_waddr = imem_waddr_q;
    assign imem_wdata = imem_wdata_q;
    assign rdata      = rdata_q;

    always_comb begin
        state_d      = state_q;
        byte_idx_d   = byte_idx_q;
        word_d       = word_q;
        len_d        = len_q;
        count_d      = count_q;
        csum_d       = csum_q;
        done_d       = done_q;
        aborted_d    = aborted_q;
        len_err_d    = len_err_q;
        imem_we_d    = 1'b0;
        imem_waddr_d = '0;
        imem_wdata_d = '0;
        rdata_d      = rdata_q;

        // Reads see register values from before any same-cycle write.
        if (sel_ren) begin
            case (sys_share_raddr)
                8'd1:    rdata_d = {{(31-IMEM_AW){1'b0}}, len_q};
                8'd2:    rdata_d = {26'd0, state_q, len_err_q, aborted_q, done_q, busy};
                8'd3:    rdata_d = {{(31-IMEM_AW){1'b0}}, count_q};
                8'd4:    rdata_d = csum_q;
                default: rdata_d = 32'd0;
            endcase
        end

        if (sel_wen && (sys_share_waddr == 8'd1) && !busy) begin
            len_d = sys_share_wdata[IMEM_AW:0];
        end

        case (state_q)
            S_RECV: begin
                if (rx_valid) begin
                    word_d[{byte_idx_q, 3'b000} +: 8] = rx_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                csum_d  = csum_q + word_q;
                count_d = count_q + 1'b1;
                if ((count_q + 1'b1) == len_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_RECV;
                end
            end
            default: begin
                if (start_req) begin
                    count_d    = '0;
                    csum_d     = '0;
                    byte_idx_d = '0;
                    word_d     = '0;
                    done_d     = 1'b0;
                    aborted_d  = 1'b0;
                    len_err_d  = 1'b0;
                    if (len_q == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else if (len_q > CAPACITY) begin
                        state_d   = S_IDLE;
                        len_err_d = 1'b1;
                    end else begin
                        state_d = S_RECV;
                    end
                end
            end
        endcase

        // An abort in WRITE keeps that cycle's COUNT/CSUM update above.
        if (abort_req) begin
            state_d    = S_IDLE;
            aborted_d  = 1'b1;
            byte_idx_d = '0;
            word_d     = '0;
        end

        if (state_d == S_WRITE) begin
            imem_we_d    = 1'b1;
            imem_waddr_d = count_d[IMEM_AW-1:0];
            imem_wdata_d = word_d;
        end
    end

    always_ff @(posedge hb_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            byte_idx_q   <= '0;
            word_q       <= '0;
            len_q        <= '0;
            count_q      <= '0;
            csum_q       <= '0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            len_err_q    <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_waddr_q <= '0;
            imem_wdata_q <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            byte_idx_q   <= byte_idx_d;
            word_q       <= word_d;
            len_q        <= len_d;
            count_q      <= count_d;
            csum_q       <= csum_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
            len_err_q    <= len_err_d;
            imem_we_q    <= imem_we_d;
            imem_waddr_q <= imem_waddr_d;
            imem_wdata_q <= imem_wdata_d;
            rdata_q      <= rdata_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_user_imem_loader.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_user_imem_loader: table-driven loads with a write scoreboard.       |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_user_imem_loader;

    localparam int IMEM_AW = 10;

    logic               hb_clk;
    logic               rst_n;
    logic               download_mode;
    logic [7:0]         rx_data;
    logic               rx_valid;
    logic               rx_ready;
    logic               imem_we;
    logic [IMEM_AW-1:0] imem_waddr;
    logic [31:0]        imem_wdata;
    logic [7:0]         sys_share_raddr;
    logic [7:0]         sys_share_waddr;
    logic [31:0]        sys_share_wdata;
    logic               sel_ren;
    logic               sel_wen;
    logic [31:0]        rdata;

    int errors = 0;
    int checks = 0;

    logic [IMEM_AW+31:0] exp_q[$];

    typedef struct {
        int          len;
        int          nbytes;
        int          gap;
        int          action;   // 0 none, 1 CTRL.abort, 2 download_mode drop
        logic [31:0] exp_status;
        int          exp_count;
    } vec_t;

    vec_t vecs[8];

    user_imem_loader #(.IMEM_AW(IMEM_AW)) dut (
        .hb_clk          (hb_clk),
        .rst_n           (rst_n),
        .download_mode   (download_mode),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .rx_ready        (rx_ready),
        .imem_we         (imem_we),
        .imem_waddr      (imem_waddr),
        .imem_wdata      (imem_wdata),
        .sys_share_raddr (sys_share_raddr),
        .sys_share_waddr (sys_share_waddr),
        .sys_share_wdata (sys_share_wdata),
        .sel_ren         (sel_ren),
        .sel_wen         (sel_wen),
        .rdata           (rdata)
    );

    initial hb_clk = 1'b0;
    always #5 hb_clk = ~hb_clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gen_byte(input int k);
        logic [7:0] kk;
        kk = 8'(k + 1);
        return kk * 8'h11;
    endfunction

    // All bus/byte tasks start and end on a falling edge.
    task automatic bus_write(input logic [7:0] off, input logic [31:0] data);
        sel_wen = 1'b1;
        sys_share_waddr = off;
        sys_share_wdata = data;
        @(negedge hb_clk);
        sel_wen = 1'b0;
        sys_share_wdata = 32'd0;
    endtask

    task automatic bus_read(input logic [7:0] off, output logic [31:0] data);
        sel_ren = 1'b1;
        sys_share_raddr = off;
        @(negedge hb_clk);
        sel_ren = 1'b0;
        data = rdata;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int tmo;
        tmo = 0;
        rx_valid = 1'b1;
        rx_data = b;
        while (!rx_ready && tmo < 200) begin
            @(negedge hb_clk);
            tmo++;
        end
        if (tmo >= 200) begin
            checks++;
            errors++;
            $display("FAIL rx_ready_timeout: got rx_ready=0 for %0d cycles expected 1", tmo);
        end else begin
            @(negedge hb_clk);
        end
        rx_valid = 1'b0;
    endtask

    // Scoreboard: every imem write must match the next expected word.
    always @(negedge hb_clk) begin
        if (rst_n === 1'b1 && imem_we === 1'b1) begin
            logic [IMEM_AW+31:0] e;
            check32("rx_ready_in_write", {31'd0, rx_ready}, 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", imem_waddr, imem_wdata);
            end else begin
                e = exp_q.pop_front();
                check32("wr_addr", {22'd0, imem_waddr}, {22'd0, e[IMEM_AW+31:32]});
                check32("wr_data", imem_wdata, e[31:0]);
            end
        end
    end

    initial begin
        logic [31:0] d;
        logic [31:0] word_m;
        logic [31:0] csum_m;
        logic [7:0]  b;

        vecs[0] = '{len: 2,    nbytes: 8,    gap: 0, action: 0, exp_status: 32'h32, exp_count: 2};
        vecs[1] = '{len: 2,    nbytes: 8,    gap: 1, action: 0, exp_status: 32'h32, exp_count: 2};
        vecs[2] = '{len: 2,    nbytes: 6,    gap: 0, action: 1, exp_status: 32'h04, exp_count: 1};
        vecs[3] = '{len: 2,    nbytes: 6,    gap: 1, action: 2, exp_status: 32'h04, exp_count: 1};
        vecs[4] = '{len: 0,    nbytes: 0,    gap: 0, action: 0, exp_status: 32'h32, exp_count: 0};
        vecs[5] = '{len: 1025, nbytes: 0,    gap: 0, action: 0, exp_status: 32'h08, exp_count: 0};
        vecs[6] = '{len: 1024, nbytes: 4096, gap: 0, action: 0, exp_status: 32'h32, exp_count: 1024};
        vecs[7] = '{len: 3,    nbytes: 12,   gap: 1, action: 0, exp_status: 32'h32, exp_count: 3};

        rst_n = 1'b0;
        download_mode = 1'b1;
        rx_data = 8'd0;
        rx_valid = 1'b0;
        sys_share_raddr = 8'd0;
        sys_share_waddr = 8'd0;
        sys_share_wdata = 32'd0;
        sel_ren = 1'b0;
        sel_wen = 1'b0;
        repeat (3) @(negedge hb_clk);
        check32("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        check32("rst_imem_we", {31'd0, imem_we}, 32'd0);
        check32("rst_waddr", {22'd0, imem_waddr}, 32'd0);
        check32("rst_wdata", imem_wdata, 32'd0);
        check32("rst_rdata", rdata, 32'd0);
        rst_n = 1'b1;
        @(negedge hb_clk);

        // Read latency: value appears only after the sampling edge.
        bus_write(8'd1, 32'd5);
        sel_ren = 1'b1;
        sys_share_raddr = 8'd1;
        #1;
        check32("rd_before_edge", rdata, 32'd0);
        @(negedge hb_clk);
        sel_ren = 1'b0;
        check32("rd_after_edge", rdata, 32'd5);
        bus_read(8'd2, d);
        check32("status_idle", d, 32'd0);
        bus_read(8'd7, d);
        check32("rd_unmapped", d, 32'd0);

        // LEN write while busy is ignored.
        bus_write(8'd1, 32'd2);
        bus_write(8'd0, 32'd1);
        bus_write(8'd1, 32'd7);
        bus_read(8'd1, d);
        check32("len_busy_hold", d, 32'd2);
        bus_read(8'd2, d);
        check32("status_recv", d, 32'h11);
        bus_read(8'd3, d);
        check32("count_after_start", d, 32'd0);
        bus_write(8'd0, 32'd2);
        bus_read(8'd2, d);
        check32("status_abort_idle", d, 32'h04);

        for (int i = 0; i < 8; i++) begin
            csum_m = 32'd0;
            word_m = 32'd0;
            bus_write(8'd1, 32'(vecs[i].len));
            bus_write(8'd0, 32'd1);
            for (int k = 0; k < vecs[i].nbytes; k++) begin
                b = gen_byte(k);
                word_m[(k % 4) * 8 +: 8] = b;
                if ((k % 4) == 3 && (k / 4) < vecs[i].len) begin
                    exp_q.push_back({IMEM_AW'(k / 4), word_m});
                    csum_m = csum_m + word_m;
                end
                if (vecs[i].gap != 0 && $urandom_range(0, 1) == 1) begin
                    repeat ($urandom_range(1, 3)) @(negedge hb_clk);
                end
                send_byte(b);
            end
            if (vecs[i].action == 1) begin
                bus_write(8'd0, 32'd2);
            end else if (vecs[i].action == 2) begin
                download_mode = 1'b0;
                @(negedge hb_clk);
                download_mode = 1'b1;
            end
            repeat (3) @(negedge hb_clk);
            bus_read(8'd2, d);
            check32($sformatf("v%0d_status", i), d, vecs[i].exp_status);
            bus_read(8'd3, d);
            check32($sformatf("v%0d_count", i), d, 32'(vecs[i].exp_count));
            bus_read(8'd4, d);
            check32($sformatf("v%0d_csum", i), d, csum_m);
            if (i == 0) check32("normal_csum_const", d, 32'hCCAA8866);
            check32($sformatf("v%0d_writes_left", i), 32'(exp_q.size()), 32'd0);
        end

        // Asynchronous reset in the middle of a word.
        bus_write(8'd1, 32'd2);
        bus_write(8'd0, 32'd1);
        send_byte(8'hA5);
        send_byte(8'h5A);
        bus_read(8'd1, d);
        check32("rdata_before_reset", d, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check32("async_rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        check32("async_rst_imem_we", {31'd0, imem_we}, 32'd0);
        check32("async_rst_rdata", rdata, 32'd0);
        @(negedge hb_clk);
        rst_n = 1'b1;
        @(negedge hb_clk);
        bus_read(8'd2, d);
        check32("status_after_reset", d, 32'd0);
        bus_read(8'd1, d);
        check32("len_after_reset", d, 32'd0);

        // Start is ignored outside download mode.
        bus_write(8'd1, 32'd1);
        download_mode = 1'b0;
        bus_write(8'd0, 32'd1);
        check32("nomode_rx_ready", {31'd0, rx_ready}, 32'd0);
        bus_read(8'd2, d);
        check32("nomode_status", d, 32'd0);
        download_mode = 1'b1;
        repeat (2) @(negedge hb_clk);
        check32("final_writes_left", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/user_imem_loader.md
Name: user_imem_loader

Overview:
- Download-mode loader that fills the user instruction memory; its contents become `user_instruction` once the core leaves bootloader mode.
- Accepts a byte stream from the UART receiver and packs bytes little-endian into 32-bit words. Writes each word to sequential imem addresses and keeps a running 32-bit checksum.
- Bootloader firmware controls and polls it through registers on the system peripheral bus.

Parameters:
- IMEM_AW, 10, user imem word-address width; capacity is 2^IMEM_AW words.

Ports:
- hb_clk  in  1  system/bus clock
- rst_n  in  1  asynchronous active-low reset
- download_mode  in  1  high while the board is in download mode; loading is only permitted while high
- rx_data  in  8  received byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader accepts a byte this cycle
- imem_we  out  1  user imem write strobe
- imem_waddr  out  IMEM_AW  user imem word address
- imem_wdata  out  32  user imem write data
- sys_share  in  sys_peripheral_t  shared peripheral bus (raddr, waddr, wdata)
- sel  in  sel_t  this peripheral's ren/wen selects
- rdata  out  32  registered read data

Behaviour:
- Reset (rst_n low, async): state IDLE, all registers 0; rx_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, rdata=0.
- Register map (word offsets):
  - 0 CTRL, W: bit0 start, bit1 abort; self-clearing, reads 0.
  - 1 LEN, R/W: bits[IMEM_AW:0], number of words to load.
  - 2 STATUS, R: bit0 busy, bit1 done, bit2 aborted, bit3 len_err, bits[5:4] state code.
  - 3 COUNT, R: words written.
  - 4 CSUM, R: checksum.
  - Other offsets read 0.
- Reads: rdata updates on the clock edge where sel.ren is high, returning the value before any same-cycle write. One-cycle latency; rdata holds when ren is low.
- LEN writes are ignored while busy.
- FSM states (code): IDLE(0), RECV(1), WRITE(2), DONE(3). busy = RECV or WRITE.
- start is honoured only in IDLE/DONE with download_mode=1; otherwise it is ignored. On an honoured start:
  - clear COUNT, CSUM, byte index, done, aborted and len_err.
  - LEN==0: go to DONE and set done.
  - LEN > 2^IMEM_AW: set len_err and stay in/return to IDLE.
  - otherwise: go to RECV.
- RECV:
  - rx_ready=1, combinationally equal to (state==RECV).
  - A byte is accepted when rx_valid && rx_ready and placed in lane byte_idx (byte 0 → bits[7:0]).
  - byte_idx increments and wraps 3→0. When the 4th byte is accepted, the state goes to WRITE on the next edge.
- WRITE (exactly one cycle; Moore outputs):
  - imem_we=1, imem_waddr=COUNT[IMEM_AW-1:0], imem_wdata=assembled word, rx_ready=0.
  - At the edge: CSUM += word (mod 2^32) and COUNT += 1.
  - If COUNT+1 == LEN, go to DONE and set done; else return to RECV.
- DONE: rx_ready=0; COUNT and CSUM hold until the next start.
- Abort conditions: CTRL.abort, or download_mode falling to 0 while busy.
  - Effect at the next edge: state IDLE, aborted=1, partial word discarded, byte_idx=0. COUNT and CSUM keep their current values.
  - An abort in the WRITE cycle still performs that cycle's write, including the COUNT/CSUM update.
  - start and abort in the same write: abort wins.
- imem_we is never asserted outside WRITE. Bytes presented while rx_ready=0 are not consumed; the upstream holds them.

Test Plan:
- Normal load: LEN=2, start, bytes 11 22 33 44 55 66 77 88 → writes at addr 0 = 0x44332211 and addr 1 = 0x88776655, one imem_we cycle each. STATUS done=1, state=3; COUNT=2; CSUM=0xCCAA8866.
- Backpressure: rx_valid toggling with gaps, plus a byte held through a WRITE cycle → no byte lost or duplicated; rx_ready=0 during WRITE; same words as the normal load.
- Abort: after 6 of 8 bytes, write CTRL.abort → STATUS aborted=1, state=0, COUNT=1, no second write. A new start clears COUNT to 0.
- download_mode drop: deassert mid-word → same result as abort. With download_mode=0, start is ignored and state stays 0.
- Boundaries:
  - LEN=0 with start → done immediately, COUNT=0, no writes.
  - LEN=2^IMEM_AW+1 → len_err=1, state IDLE.
  - Load of 2^IMEM_AW words → last write at addr 2^IMEM_AW-1, then DONE.
- Reset and bus: assert rst_n low during RECV → all outputs 0 asynchronously. Register read has one-cycle latency. A LEN write while busy leaves LEN unchanged.
